regfile_wr_arbiter: RTL and testbench

Shares the single write port of the 8 x 8-bit register file between two writeback requesters: A (ALU result) and B (load data). Each requester gets a one-entry holding slot with a valid/ready handshake, and slots drain through a round-robin arbiter into `WriteEn`/`Waddr`/`DataIn`. A per-register pending vector lets decode stall on in-flight writes.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_wr_slot.sv | 47 ++++
 rtl/regfile_wr_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback path.
// Pure declarations; no timing or flow control of its own.
package regfile_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } wr_src_e;
endpackage

// File: rtl/regfile_wr_slot.sv
// One-entry write holding slot: loads on valid && ready, empties when granted.
// Zero-bubble: ready stays high through a grant, so a drain and a refill share one edge.
module regfile_wr_slot
  import regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    valid_i,
  input  wr_req_t req_i,
  output logic    ready_o,
  input  logic    grant_i,
  output logic    full_o,
  output wr_req_t req_o
);

  logic    full_q, full_d;
  wr_req_t req_q, req_d;
  logic    load;

  assign ready_o = !rst_i && (!full_q || grant_i);
  assign load    = valid_i && ready_o;

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (load) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two writeback requesters share the register-file write port via one slot each and a
// round-robin arbiter; a write is presented the cycle after acceptance, loser's ready stays low.
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqA_Valid,
  input  logic [ADDR_W-1:0]   ReqA_Addr,
  input  logic [DATA_W-1:0]   ReqA_Data,
  output logic                ReqA_Ready,
  input  logic                ReqB_Valid,
  input  logic [ADDR_W-1:0]   ReqB_Addr,
  input  logic [DATA_W-1:0]   ReqB_Data,
  output logic                ReqB_Ready,
  output logic                WriteEn,
  output logic [ADDR_W-1:0]   Waddr,
  output logic [DATA_W-1:0]   DataIn,
  output logic [NUM_REGS-1:0] Pending
);

  wr_req_t in_a, in_b, slot_a, slot_b;
  logic    full_a, full_b, grant_a, grant_b, load_a, load_b;
  wr_src_e gsel, rr_q, rr_d;
  logic    a_older_q, a_older_d;

  assign in_a = '{addr: ReqA_Addr, data: ReqA_Data};
  assign in_b = '{addr: ReqB_Addr, data: ReqB_Data};

  regfile_wr_slot u_slot_a (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .valid_i (ReqA_Valid),
    .req_i   (in_a),
    .ready_o (ReqA_Ready),
    .grant_i (grant_a),
    .full_o  (full_a),
    .req_o   (slot_a)
  );

  regfile_wr_slot u_slot_b (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .valid_i (ReqB_Valid),
    .req_i   (in_b),
    .ready_o (ReqB_Ready),
    .grant_i (grant_b),
    .full_o  (full_b),
    .req_o   (slot_b)
  );

  assign load_a = ReqA_Valid && ReqA_Ready;
  assign load_b = ReqB_Valid && ReqB_Ready;

  // Same-address contention must drain the older write first so the younger one lands last.
  always_comb begin
    gsel = SRC_A;
    if (full_a && full_b) begin
      if (slot_a.addr == slot_b.addr) gsel = a_older_q ? SRC_A : SRC_B;
      else                            gsel = rr_q;
    end else if (full_b) begin
      gsel = SRC_B;
    end
  end

  assign grant_a = !Reset && full_a && (gsel == SRC_A);
  assign grant_b = !Reset && full_b && (gsel == SRC_B);

  always_comb begin
    rr_d      = rr_q;
    a_older_d = a_older_q;
    if (full_a && full_b) rr_d = (gsel == SRC_A) ? SRC_B : SRC_A;
    if (load_a && load_b)  a_older_d = 1'b1;
    else if (load_a)       a_older_d = !(full_b && !grant_b);
    else if (load_b)       a_older_d = full_a && !grant_a;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_q      <= SRC_A;
      a_older_q <= 1'b1;
    end else begin
      rr_q      <= rr_d;
      a_older_q <= a_older_d;
    end
  end

  // Outputs are forced quiet during reset so buffered writes never reach the register file.
  assign WriteEn = !Reset && (full_a || full_b);

  always_comb begin
    Waddr   = '0;
    DataIn  = '0;
    Pending = '0;
    if (grant_a) begin
      Waddr  = slot_a.addr;
      DataIn = slot_a.data;
    end else if (grant_b) begin
      Waddr  = slot_b.addr;
      DataIn = slot_b.data;
    end
    if (!Reset) begin
      if (full_a) Pending[slot_a.addr] = 1'b1;
      if (full_b) Pending[slot_b.addr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised and directed bench with a queue-based scoreboard for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                ReqA_Valid, ReqB_Valid, ReqA_Ready, ReqB_Ready;
  logic [ADDR_W-1:0]   ReqA_Addr, ReqB_Addr, Waddr;
  logic [DATA_W-1:0]   ReqA_Data, ReqB_Data, DataIn;
  logic                WriteEn;
  logic [NUM_REGS-1:0] Pending;

  always #5 Clk = ~Clk;

  regfile_wr_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqA_Valid (ReqA_Valid),
    .ReqA_Addr  (ReqA_Addr),
    .ReqA_Data  (ReqA_Data),
    .ReqA_Ready (ReqA_Ready),
    .ReqB_Valid (ReqB_Valid),
    .ReqB_Addr  (ReqB_Addr),
    .ReqB_Data  (ReqB_Data),
    .ReqB_Ready (ReqB_Ready),
    .WriteEn    (WriteEn),
    .Waddr      (Waddr),
    .DataIn     (DataIn),
    .Pending    (Pending)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                seq;
    int                cyc;
  } ent_t;

  ent_t              qa[$];
  ent_t              qb[$];
  logic [DATA_W-1:0] rf        [NUM_REGS];
  logic [DATA_W-1:0] exp_final [NUM_REGS];
  int                errors = 0;
  int                checks = 0;
  int                cyc = 0;
  int                seq = 0;
  int                wr_count = 0;
  bit                rr_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected grant follows the arbitration rules applied to the pending requests.
  always @(negedge Clk) begin
    bit                has_a, has_b, gb;
    logic [NUM_REGS-1:0] exp_pend;
    ent_t              e;
    cyc++;
    if (WriteEn === 1'b1) rf[Waddr] = DataIn;
    if (Reset) begin
      chk("reset_writeen", 32'(WriteEn), 32'd0);
      chk("reset_pending", 32'(Pending), 32'd0);
      chk("reset_ready", 32'({ReqA_Ready, ReqB_Ready}), 32'd0);
      qa.delete();
      qb.delete();
      rr_b = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) exp_final[r] = rf[r];
    end else begin
      has_a = (qa.size() != 0);
      has_b = (qb.size() != 0);
      if (has_a && has_b)
        gb = (qa[0].addr == qb[0].addr) ? (qb[0].seq < qa[0].seq) : rr_b;
      else
        gb = has_b;
      exp_pend = '0;
      if (has_a) exp_pend[qa[0].addr] = 1'b1;
      if (has_b) exp_pend[qb[0].addr] = 1'b1;
      chk("writeen", 32'(WriteEn), 32'(has_a || has_b));
      chk("pending", 32'(Pending), 32'(exp_pend));
      chk("ready_a", 32'(ReqA_Ready), 32'(!has_a || !gb));
      chk("ready_b", 32'(ReqB_Ready), 32'(!has_b || gb));
      if (has_a || has_b) begin
        e = gb ? qb.pop_front() : qa.pop_front();
        chk("waddr", 32'(Waddr), 32'(e.addr));
        chk("datain", 32'(DataIn), 32'(e.data));
        chk("latency", 32'((cyc - e.cyc) <= 2), 32'd1);
        if (has_a && has_b) rr_b = !gb;
        wr_count++;
      end
      if (ReqA_Valid && ReqA_Ready) begin
        qa.push_back('{ReqA_Addr, ReqA_Data, seq, cyc});
        seq++;
        exp_final[ReqA_Addr] = ReqA_Data;
      end
      if (ReqB_Valid && ReqB_Ready) begin
        qb.push_back('{ReqB_Addr, ReqB_Data, seq, cyc});
        seq++;
        exp_final[ReqB_Addr] = ReqB_Data;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic g;
    g = 1'b0;
    ReqA_Valid = 1'b1; ReqA_Addr = a; ReqA_Data = d;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge Clk);
      g = ReqA_Ready;
      @(posedge Clk);
      #1;
    end
    if (!g) chk("send_a_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic g;
    g = 1'b0;
    ReqB_Valid = 1'b1; ReqB_Addr = a; ReqB_Data = d;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge Clk);
      g = ReqB_Ready;
      @(posedge Clk);
      #1;
    end
    if (!g) chk("send_b_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic va, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                      input logic vb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    fork
      if (va) send_a(aa, da);
      if (vb) send_b(ab, db);
    join
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] b4, b5;
    int                w0;
    for (int r = 0; r < NUM_REGS; r++) begin
      rf[r] = '0;
      exp_final[r] = '0;
    end
    Reset = 1'b1;
    ReqA_Valid = 1'b1; ReqA_Addr = 3'd1; ReqA_Data = 8'd11;
    ReqB_Valid = 1'b1; ReqB_Addr = 3'd2; ReqB_Data = 8'd12;
    idle(2);
    Reset = 1'b0;
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b0;
    chk("reset_no_write_r1", 32'(rf[1]), 32'd0);
    chk("reset_no_write_r2", 32'(rf[2]), 32'd0);

    send(1'b1, 3'd2, 8'd22, 1'b0, 3'd0, 8'd0);
    idle(1);
    chk("single_rf2", 32'(rf[2]), 32'd22);

    send(1'b1, 3'd3, 8'd16, 1'b1, 3'd1, 8'd8);
    @(negedge Clk);
    chk("conflict_first_addr", 32'(Waddr), 32'd3);
    chk("conflict_b_stalled", 32'(ReqB_Ready), 32'd0);
    @(negedge Clk);
    chk("conflict_second_addr", 32'(Waddr), 32'd1);
    idle(2);
    chk("conflict_rf3", 32'(rf[3]), 32'd16);
    chk("conflict_rf1", 32'(rf[1]), 32'd8);

    send(1'b1, 3'd7, 8'd5, 1'b1, 3'd0, 8'd1);
    send(1'b0, 3'd0, 8'd0, 1'b1, 3'd7, 8'd15);
    idle(4);
    chk("same_addr_a_first", 32'(rf[7]), 32'd15);
    send(1'b1, 3'd0, 8'd2, 1'b1, 3'd6, 8'd9);
    send(1'b1, 3'd6, 8'd33, 1'b0, 3'd0, 8'd0);
    idle(4);
    chk("same_addr_b_first", 32'(rf[6]), 32'd33);
    send(1'b1, 3'd5, 8'd40, 1'b1, 3'd5, 8'd41);
    idle(4);
    chk("same_addr_same_cycle", 32'(rf[5]), 32'd41);

    w0 = wr_count;
    fork
      begin
        for (int i = 0; i < 5; i++) send_a(3'(i), 8'(8'h60 + i));
        ReqA_Valid = 1'b0;
      end
      begin
        for (int j = 0; j < 5; j++) send_b(3'(7 - j), 8'(8'h70 + j));
        ReqB_Valid = 1'b0;
      end
    join
    idle(4);
    chk("sustained_write_count", 32'(wr_count - w0), 32'd10);

    b4 = rf[4];
    b5 = rf[5];
    send(1'b1, 3'd4, 8'd77, 1'b1, 3'd5, 8'd88);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    idle(3);
    chk("midreset_rf4_kept", 32'(rf[4]), 32'(b4));
    chk("midreset_rf5_kept", 32'(rf[5]), 32'(b5));
    chk("midreset_pending", 32'(Pending), 32'd0);
    send(1'b1, 3'd4, 8'd99, 1'b0, 3'd0, 8'd0);
    idle(1);
    chk("after_reset_rf4", 32'(rf[4]), 32'd99);

    for (int i = 0; i < 400; i++) begin
      ReqA_Valid = ($urandom_range(0, 9) < 7);
      ReqA_Addr  = 3'($urandom_range(0, 3));
      ReqA_Data  = 8'($urandom);
      ReqB_Valid = ($urandom_range(0, 9) < 7);
      ReqB_Addr  = 3'($urandom_range(0, 3));
      ReqB_Data  = 8'($urandom);
      idle(1);
    end
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b0;
    idle(4);
    for (int r = 0; r < NUM_REGS; r++) chk("final_reg", 32'(rf[r]), 32'(exp_final[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
